// File: rtl/hash_serializer.sv
// Hash serializer: buffers 128-bit hashes in a small FIFO and sends each one
// as a 16-byte frame, most significant byte first, with sop/eop markers.
module hash_serializer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_valid,
    input  logic [127:0]                 i_hash,
    output logic                         o_tx_valid,
    output logic [7:0]                   o_tx_data,
    output logic                         o_tx_sop,
    output logic                         o_tx_eop,
    input  logic                         i_tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]  o_level,
    output logic                         o_overflow,
    output logic [15:0]                  o_drop_cnt,
    input  logic                         i_clear
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned HW = 128;
    localparam int unsigned CW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   shift_q, shift_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tx_valid_q, tx_valid_d;
    logic            tx_sop_q, tx_sop_d;
    logic            tx_eop_q, tx_eop_d;

    logic [HW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic            overflow_q;
    logic [15:0]     drop_cnt_q;

    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push;
    logic            drop;
    logic            xfer;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
    assign xfer       = (state_q == SEND) && i_tx_ready;
    assign push       = i_valid && (!fifo_full || pop);
    assign drop       = i_valid && fifo_full && !pop;

    // FIFO storage; the head is read combinationally, so a full FIFO can
    // accept a new entry in the same cycle its head is popped.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_hash;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            end
            level_q <= level_q + LW'(push) - LW'(pop);
        end
    end

    // Sticky overflow flag and saturating drop counter; a drop wins over clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (i_clear) begin
            overflow_q <= drop;
            drop_cnt_q <= drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    // FSM state, shift register, byte counter and registered frame outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_sop_q   <= 1'b0;
            tx_eop_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_sop_q   <= tx_sop_d;
            tx_eop_q   <= tx_eop_d;
        end
    end

    // Next-state logic: load on pop, shift per transferred byte, chain frames
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (cnt_q != CW'(15)) begin
                        shift_d = {shift_q[HW-9:0], 8'h00};
                        cnt_d   = cnt_q + CW'(1);
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        cnt_d   = '0;
                    end else begin
                        shift_d = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_valid_d = (state_d == SEND);
        tx_sop_d   = (state_d == SEND) && (cnt_d == CW'(0));
        tx_eop_d   = (state_d == SEND) && (cnt_d == CW'(15));
    end

    assign o_tx_valid = tx_valid_q;
    assign o_tx_data  = shift_q[HW-1 -: 8];
    assign o_tx_sop   = tx_sop_q;
    assign o_tx_eop   = tx_eop_q;
    assign o_level    = level_q;
    assign o_overflow = overflow_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_hash_serializer.sv
// Bench for hash_serializer: scoreboard of expected bytes plus table-driven
// single-frame vectors and hand-written multi-cycle sequences.
module tb_hash_serializer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_valid;
    logic [127:0]    i_hash;
    logic            o_tx_valid;
    logic [7:0]      o_tx_data;
    logic            o_tx_sop;
    logic            o_tx_eop;
    logic            i_tx_ready;
    logic [LW-1:0]   o_level;
    logic            o_overflow;
    logic [15:0]     o_drop_cnt;
    logic            i_clear;

    hash_serializer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_hash     (i_hash),
        .o_tx_valid (o_tx_valid),
        .o_tx_data  (o_tx_data),
        .o_tx_sop   (o_tx_sop),
        .o_tx_eop   (o_tx_eop),
        .i_tx_ready (i_tx_ready),
        .o_level    (o_level),
        .o_overflow (o_overflow),
        .o_drop_cnt (o_drop_cnt),
        .i_clear    (i_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] hash;
        bit           alt;
        int           exp_cyc;
    } vec_t;

    int          errs   = 0;
    int          checks = 0;
    logic [9:0]  sb[$];
    int          vcyc   = 0;
    int          nxfer  = 0;
    logic        stall_prev = 1'b0;
    logic        frame_open = 1'b0;
    logic [9:0]  prev_out   = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] h, input int i);
        return h[127 - 8*i -: 8];
    endfunction

    task automatic push_hash(input logic [127:0] h);
        for (int i = 0; i < 16; i++) begin
            sb.push_back({byte_of(h, i), logic'(i == 0), logic'(i == 15)});
        end
    endtask

    // Checks the byte presented at this negedge against the scoreboard when it
    // will transfer at the coming edge; also checks stall hold and no gaps.
    task automatic monitor();
        logic [9:0] cur;
        logic [9:0] exp;
        cur = {o_tx_data, o_tx_sop, o_tx_eop};
        if (frame_open) chk("no_gap_valid", 128'(o_tx_valid), 128'(1));
        if (stall_prev && o_tx_valid) chk("stall_hold", 128'(cur), 128'(prev_out));
        if (o_tx_valid) begin
            vcyc++;
            if (i_tx_ready) begin
                nxfer++;
                if (sb.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_byte: got %0h expected none", cur);
                end else begin
                    exp = sb.pop_front();
                    chk("byte_data_sop_eop", 128'(cur), 128'(exp));
                end
            end
        end
        frame_open = o_tx_valid && !(i_tx_ready && o_tx_eop);
        stall_prev = o_tx_valid && !i_tx_ready;
        prev_out   = cur;
    endtask

    task automatic cycle(input logic v, input logic [127:0] h, input logic r,
                         input logic c, input logic acc);
        i_valid    = v;
        i_hash     = h;
        i_tx_ready = r;
        i_clear    = c;
        if (v && acc) push_hash(h);
        monitor();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs until the scoreboard empties; alt stalls each byte for one cycle
    task automatic drain(input bit alt, output int ncyc, output int first, output int last);
        int   g;
        int   fv;
        logic r;
        g = 0; fv = 0; ncyc = 0; first = -1; last = -1;
        while (sb.size() != 0 && g < 400) begin
            r = alt ? logic'(fv % 2 == 1) : 1'b1;
            if (o_tx_valid) begin
                if (first < 0) first = g;
                last = g;
                fv++;
                ncyc++;
            end
            cycle(1'b0, '0, r, 1'b0, 1'b0);
            g++;
        end
        if (sb.size() != 0) begin
            checks++;
            errs++;
            $display("FAIL drain_timeout: got %0d bytes left expected 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [127:0] mk(input int k);
        return {32'(k) * 32'h01010101, 32'hDEADBEEF ^ 32'(k), 32'h12345678, 32'(k)};
    endfunction

    initial begin
        vec_t vecs[4];
        int   n, f, l, base, g;
        logic [127:0] ha, hb;

        vecs[0] = '{128'h000102030405060708090A0B0C0D0E0F, 1'b0, 16};
        vecs[1] = '{128'h000102030405060708090A0B0C0D0E0F, 1'b1, 32};
        vecs[2] = '{128'hFFEEDDCCBBAA99887766554433221100, 1'b0, 16};
        vecs[3] = '{128'h80000000000000000000000000000001, 1'b1, 32};

        rst_n = 1'b0; i_valid = 1'b0; i_hash = '0; i_tx_ready = 1'b0; i_clear = 1'b0;
        #12;
        chk("rst_valid", 128'(o_tx_valid), 128'(0));
        chk("rst_data", 128'(o_tx_data), 128'(0));
        chk("rst_sop_eop", 128'({o_tx_sop, o_tx_eop}), 128'(0));
        chk("rst_level", 128'(o_level), 128'(0));
        chk("rst_overflow", 128'(o_overflow), 128'(0));
        chk("rst_drop_cnt", 128'(o_drop_cnt), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single frames with latency check
        for (int v = 0; v < 4; v++) begin
            cycle(1'b1, vecs[v].hash, 1'b1, 1'b0, 1'b1);
            chk("lat_not_yet_valid", 128'(o_tx_valid), 128'(0));
            chk("lat_level_one", 128'(o_level), 128'(1));
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            chk("lat_first_valid", 128'(o_tx_valid), 128'(1));
            chk("lat_first_sop", 128'(o_tx_sop), 128'(1));
            chk("lat_first_byte", 128'(o_tx_data), 128'(byte_of(vecs[v].hash, 0)));
            drain(vecs[v].alt, n, f, l);
            chk("frame_cycles", 128'(n), 128'(vecs[v].exp_cyc));
            chk("frame_contiguous", 128'(l - f + 1), 128'(vecs[v].exp_cyc));
            chk("frame_end_valid", 128'(o_tx_valid), 128'(0));
            chk("frame_end_level", 128'(o_level), 128'(0));
        end

        // back-to-back hashes
        cycle(1'b1, mk(1), 1'b1, 1'b0, 1'b1);
        cycle(1'b1, mk(2), 1'b1, 1'b0, 1'b1);
        drain(1'b0, n, f, l);
        chk("b2b_cycles", 128'(n), 128'(32));
        chk("b2b_contiguous", 128'(l - f + 1), 128'(32));
        chk("b2b_level", 128'(o_level), 128'(0));
        chk("b2b_end_valid", 128'(o_tx_valid), 128'(0));

        // overflow with downstream stalled
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, mk(10 + k), 1'b0, 1'b0, logic'(k < 5));
        end
        chk("ovf_level", 128'(o_level), 128'(4));
        chk("ovf_flag", 128'(o_overflow), 128'(1));
        chk("ovf_drop_cnt", 128'(o_drop_cnt), 128'(1));
        chk("ovf_head_byte", 128'(o_tx_data), 128'(byte_of(mk(10), 0)));
        cycle(1'b1, mk(16), 1'b0, 1'b1, 1'b0);
        chk("clr_drop_flag", 128'(o_overflow), 128'(1));
        chk("clr_drop_cnt", 128'(o_drop_cnt), 128'(1));
        cycle(1'b1, mk(17), 1'b0, 1'b0, 1'b0);
        chk("drop_cnt_two", 128'(o_drop_cnt), 128'(2));
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("clr_flag", 128'(o_overflow), 128'(0));
        chk("clr_cnt", 128'(o_drop_cnt), 128'(0));
        drain(1'b0, n, f, l);
        chk("ovf_drain_cycles", 128'(n), 128'(80));
        chk("ovf_drain_level", 128'(o_level), 128'(0));

        // reset during byte 7
        ha = mk(20); hb = mk(21);
        cycle(1'b1, ha, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, hb, 1'b1, 1'b0, 1'b1);
        base = nxfer; g = 0;
        while (nxfer - base < 7 && g < 50) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            g++;
        end
        chk("pre_rst_byte7", 128'(o_tx_data), 128'(byte_of(ha, 7)));
        chk("pre_rst_level", 128'(o_level), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 128'(o_tx_valid), 128'(0));
        chk("async_rst_level", 128'(o_level), 128'(0));
        chk("async_rst_data", 128'(o_tx_data), 128'(0));
        chk("async_rst_sop_eop", 128'({o_tx_sop, o_tx_eop}), 128'(0));
        sb.delete();
        frame_open = 1'b0;
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base = vcyc;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        chk("post_rst_no_valid", 128'(vcyc - base), 128'(0));
        chk("post_rst_level", 128'(o_level), 128'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/hash_serializer.md
HASH_SERIALIZER -- requirements
Module: hash_serializer

Interface
REQ-001 The module SHALL have one parameter: FIFO_DEPTH, default 4, meaning the number of 128-bit hash entries buffered (power of two, 2..16).
REQ-002 The module SHALL have the following ports, one clock and reset asynchronous active-low:
- clk  input  1  sole clock; all state on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  hash-valid strobe from the validator pipeline; no backpressure.
- i_hash  input  128  hash word, sampled when i_valid=1.
- o_tx_valid  output  1  byte-stream valid.
- o_tx_data  output  8  byte-stream data, MSB byte of the hash first.
- o_tx_sop  output  1  first byte of a hash frame.
- o_tx_eop  output  1  last (16th) byte of a hash frame.
- i_tx_ready  input  1  downstream ready; a byte transfers when o_tx_valid and i_tx_ready are both 1.
- o_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy, excluding the frame being sent.
- o_overflow  output  1  sticky flag, set when a hash is dropped.
- o_drop_cnt  output  16  saturating count of dropped hashes.
- i_clear  input  1  synchronous clear of o_overflow and o_drop_cnt.

Function
REQ-003 The FIFO SHALL write i_hash on i_valid=1 when not full, or when full and a pop occurs in the same cycle.
REQ-004 On i_valid=1 with the FIFO full and no same-cycle pop, the hash SHALL be dropped, o_overflow set to 1, and o_drop_cnt incremented, saturating at 16'hFFFF.
REQ-005 i_clear=1 SHALL zero o_overflow and o_drop_cnt next cycle, unless a drop occurs in the same cycle, in which case o_overflow=1 and o_drop_cnt=1.
REQ-006 The FSM SHALL have two states: IDLE and SEND.
REQ-007 In IDLE with the FIFO non-empty, the FSM SHALL pop the head into a 128-bit shift register, clear the byte counter, and enter SEND.
REQ-008 In IDLE with the FIFO empty, the FSM SHALL stay in IDLE.
REQ-009 In SEND, the outputs SHALL be: o_tx_valid=1, o_tx_data=shift[127:120], o_tx_sop=(counter==0), o_tx_eop=(counter==15).
REQ-010 On a transfer with counter<15, the shift register SHALL shift left by 8 and the counter SHALL increment.
REQ-011 On a transfer with counter==15 and the FIFO non-empty, the FSM SHALL pop and load the next hash in the same cycle, with no bubble and remaining in SEND.
REQ-012 On a transfer with counter==15 and the FIFO empty, the FSM SHALL return to IDLE.
REQ-013 While o_tx_valid=1 and i_tx_ready=0, o_tx_data, o_tx_sop and o_tx_eop SHALL hold stable.
REQ-014 o_tx_valid SHALL NOT deassert mid-frame.
REQ-015 Latency: with the FSM in IDLE and the FIFO empty, i_valid sampled at edge N SHALL give o_tx_valid=1 with the first byte after edge N+1.
REQ-016 o_level SHALL equal writes minus pops, updated each edge; a simultaneous write and pop SHALL leave it unchanged.
REQ-017 i_tx_ready SHALL be ignored while o_tx_valid=0.

Reset
REQ-018 While rst_n=0, regardless of clk, the module SHALL force:
- FSM to IDLE, FIFO pointers empty, shift register and counter to 0.
- o_tx_valid=0, o_tx_data=0, o_tx_sop=0, o_tx_eop=0.
- o_level=0, o_overflow=0, o_drop_cnt=0.
REQ-019 Reset asserted mid-frame SHALL abandon the frame and all buffered hashes; no partial frame SHALL resume after release.

Verification
REQ-020 Single hash: i_hash=128'h000102030405060708090A0B0C0D0E0F, i_tx_ready=1 -> bytes 00..0F on 16 consecutive cycles; sop with 00, eop with 0F; first valid 2 edges after i_valid.
REQ-021 Backpressure: same hash, i_tx_ready alternating 1/0 -> each byte held through its stall cycle; frame completes in 32 cycles; order unchanged.
REQ-022 Back-to-back: two hashes on consecutive cycles, i_tx_ready=1 -> 32 consecutive valid cycles; sop at bytes 0 and 16, eop at bytes 15 and 31; o_level returns to 0.
REQ-023 Overflow: i_tx_ready=0, six hashes on consecutive cycles, FIFO_DEPTH=4 -> hash 1 in the shift register, hashes 2-5 buffered, hash 6 dropped; o_level=4, o_overflow=1, o_drop_cnt=1.
REQ-024 Clear: after REQ-023, i_clear=1 together with another drop -> o_drop_cnt=1, o_overflow=1; i_clear=1 alone -> both 0.
REQ-025 Reset mid-frame: rst_n=0 during byte 7 -> o_tx_valid=0 and o_level=0 immediately, without a clock edge; after release with no input, o_tx_valid stays 0.
